alu_uop_decoder: RTL

Registered decode stage that turns RV32I instructions into the 4-bit ALU micro-opcode, operand-select controls and immediate consumed by the integer ALU. Sits between fetch and the execute/register-read stage, with valid/ready handshakes on both sides and a 2-entry skid buffer so it sustains one instruction per cycle under backpressure. Flushable by the branch/exception unit.

---
 rtl/alu_uop_decoder.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_uop_decoder.sv
// alu_uop_decoder
//   Registered RV32I decode stage. It turns an instruction word into the
//   4-bit ALU micro-opcode, the operand-select controls, the immediate and
//   the register indices used by the integer ALU.
//   An output register (entry 0) and a skid register (entry 1) let the stage
//   keep one instruction per cycle flowing while the downstream side stalls.
//
// Build option:
//   ALU_DEC_ILLEGAL_CHECK_EN - when defined, unsupported encodings raise
//   illegal_out. When undefined, illegal_out is tied 0. In both cases such
//   entries decode as ADD rs1+rs2 with rd_we_out=0 and still pass through
//   the handshake.
//
// Ports:
//   clk_in, rst_n_in        clock (rising edge), async active-low reset
//   flush_in                drop every held entry at the next edge
//   instr_in, pc_in         instruction word and its address
//   valid_in / ready_out    upstream handshake
//   valid_out / ready_in    downstream handshake
//   uop_out                 ALU micro-opcode
//   a_sel_out, b_sel_out    operand A: 0=rs1 1=PC, operand B: 0=rs2 1=imm
//   imm_out                 sign-extended immediate (shamt for shifts)
//   rs1_out, rs2_out, rd_out register indices
//   rd_we_out               entry writes rd
//   pc_out                  PC of the decoded entry
//   illegal_out             unsupported encoding
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; valid is held with stable data until that edge, and ready does not
// depend on valid of the same interface.
module alu_uop_decoder #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  flush_in,
   input  logic [DATA_WIDTH-1:0] instr_in,
   input  logic [DATA_WIDTH-1:0] pc_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [3:0]            uop_out,
   output logic                  a_sel_out,
   output logic                  b_sel_out,
   output logic [DATA_WIDTH-1:0] imm_out,
   output logic [4:0]            rs1_out,
   output logic [4:0]            rs2_out,
   output logic [4:0]            rd_out,
   output logic                  rd_we_out,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic                  illegal_out
);

   localparam logic [3:0] UOP_ADD  = 4'b0000;
   localparam logic [3:0] UOP_SUB  = 4'b0001;
   localparam logic [3:0] UOP_OR   = 4'b0010;
   localparam logic [3:0] UOP_AND  = 4'b0011;
   localparam logic [3:0] UOP_XOR  = 4'b0100;
   localparam logic [3:0] UOP_BUFB = 4'b1001;
   localparam logic [3:0] UOP_SLT  = 4'b1010;
   localparam logic [3:0] UOP_SLTU = 4'b1011;
   localparam logic [3:0] UOP_SRA  = 4'b1101;
   localparam logic [3:0] UOP_SRL  = 4'b1110;
   localparam logic [3:0] UOP_SLL  = 4'b1111;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]            uop;
      logic                  a_sel;
      logic                  b_sel;
      logic [DATA_WIDTH-1:0] imm;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic                  rd_we;
      logic [DATA_WIDTH-1:0] pc;
      logic                  illegal;
   } entry_t;

   // funct3 map shared by OP and OP-IMM for the codes without a funct7 variant
   function automatic logic [3:0] f3_uop(input logic [2:0] f3);
      case (f3)
         3'b001:  f3_uop = UOP_SLL;
         3'b010:  f3_uop = UOP_SLT;
         3'b011:  f3_uop = UOP_SLTU;
         3'b100:  f3_uop = UOP_XOR;
         3'b110:  f3_uop = UOP_OR;
         3'b111:  f3_uop = UOP_AND;
         default: f3_uop = UOP_ADD;
      endcase
   endfunction

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_u, imm_shamt;

   assign opcode    = instr_in[6:0];
   assign funct3    = instr_in[14:12];
   assign funct7    = instr_in[31:25];
   assign imm_i     = {{20{instr_in[31]}}, instr_in[31:20]};
   assign imm_s     = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
   assign imm_u     = {instr_in[31:12], 12'b0};
   assign imm_shamt = {27'b0, instr_in[24:20]};

   entry_t dec;
   logic   bad;

   always_comb begin
      dec       = '0;
      bad       = 1'b0;
      dec.rs1   = instr_in[19:15];
      dec.rs2   = instr_in[24:20];
      dec.rd    = instr_in[11:7];
      dec.pc    = pc_in;
      case (opcode)
         OPC_OP: begin
            dec.rd_we = 1'b1;
            case (funct3)
               3'b000: begin
                  if (funct7 == F7_BASE)     dec.uop = UOP_ADD;
                  else if (funct7 == F7_ALT) dec.uop = UOP_SUB;
                  else                       bad = 1'b1;
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     dec.uop = UOP_SRL;
                  else if (funct7 == F7_ALT) dec.uop = UOP_SRA;
                  else                       bad = 1'b1;
               end
               default: begin
                  dec.uop = f3_uop(funct3);
                  if (funct7 != F7_BASE) bad = 1'b1;
               end
            endcase
         end
         OPC_OP_IMM: begin
            dec.rd_we = 1'b1;
            dec.b_sel = 1'b1;
            dec.imm   = imm_i;
            case (funct3)
               3'b000: dec.uop = UOP_ADD;
               3'b001: begin
                  dec.uop = UOP_SLL;
                  dec.imm = imm_shamt;
                  if (funct7 != F7_BASE) bad = 1'b1;
               end
               3'b101: begin
                  dec.imm = imm_shamt;
                  if (funct7 == F7_BASE)     dec.uop = UOP_SRL;
                  else if (funct7 == F7_ALT) dec.uop = UOP_SRA;
                  else                       bad = 1'b1;
               end
               default: dec.uop = f3_uop(funct3);
            endcase
         end
         OPC_LUI: begin
            dec.uop   = UOP_BUFB;
            dec.b_sel = 1'b1;
            dec.imm   = imm_u;
            dec.rd_we = 1'b1;
         end
         OPC_AUIPC: begin
            dec.uop   = UOP_ADD;
            dec.a_sel = 1'b1;
            dec.b_sel = 1'b1;
            dec.imm   = imm_u;
            dec.rd_we = 1'b1;
         end
         OPC_LOAD: begin
            dec.uop   = UOP_ADD;
            dec.b_sel = 1'b1;
            dec.imm   = imm_i;
            dec.rd_we = 1'b1;
         end
         OPC_STORE: begin
            dec.uop   = UOP_ADD;
            dec.b_sel = 1'b1;
            dec.imm   = imm_s;
         end
         default: bad = 1'b1;
      endcase
      // Unsupported encodings collapse to a harmless ADD rs1+rs2 without writeback
      if (bad) begin
         dec.uop   = UOP_ADD;
         dec.a_sel = 1'b0;
         dec.b_sel = 1'b0;
         dec.imm   = '0;
         dec.rd_we = 1'b0;
      end
`ifdef ALU_DEC_ILLEGAL_CHECK_EN
      dec.illegal = bad;
`else
      dec.illegal = 1'b0;
`endif
   end

   // Two-entry buffer: entry 0 drives the outputs, entry 1 is the skid.
   // The skid is only ever valid while entry 0 is valid.
   entry_t e0, e1;
   logic   v0, v1;
   logic   accept, xfer;

   assign ready_out = !v1;
   assign accept    = valid_in && ready_out;
   assign xfer      = v0 && ready_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         e0 <= '0;
         e1 <= '0;
      end else if (flush_in) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (v1) begin
         // Skid full means upstream is blocked; only a drain can happen
         if (xfer) begin
            e0 <= e1;
            v1 <= 1'b0;
         end
      end else if (accept) begin
         if (!v0 || xfer) begin
            e0 <= dec;
            v0 <= 1'b1;
         end else begin
            e1 <= dec;
            v1 <= 1'b1;
         end
      end else if (xfer) begin
         v0 <= 1'b0;
      end
   end

   assign valid_out   = v0;
   assign uop_out     = e0.uop;
   assign a_sel_out   = e0.a_sel;
   assign b_sel_out   = e0.b_sel;
   assign imm_out     = e0.imm;
   assign rs1_out     = e0.rs1;
   assign rs2_out     = e0.rs2;
   assign rd_out      = e0.rd;
   assign rd_we_out   = e0.rd_we;
   assign pc_out      = e0.pc;
   assign illegal_out = e0.illegal;

endmodule
